// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its
// operand forwarding logic.
package id_ex_pipeline_reg_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_SEL_W  = 4;

    // Named ALU codes; any other 4-bit code travels through the slot untouched.
    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_FWD = 4'b0000,
        ALU_ADD = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_sel_e;

    typedef enum logic [1:0] {
        FWD_REGFILE,
        FWD_EXM,
        FWD_MWB
    } fwd_src_e;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [ALU_SEL_W-1:0]  alu_select;
        logic                  alusrc;
        logic                  mem_read;
        logic                  reg_write;
    } ex_slot_t;

    // An empty EX slot: no side effects, all fields zero, ALU code FWD.
    function automatic ex_slot_t bubble();
        ex_slot_t b;
        b            = '0;
        b.alu_select = ALU_FWD;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Bundle of decode-side inputs, forwarding sources and EX-slot outputs
// exchanged between the decode stage and the ID/EX register.
interface id_ex_pipeline_reg_if;
    import id_ex_pipeline_reg_pkg::*;

    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic [ALU_SEL_W-1:0]  id_alu_select;
    logic                  id_alusrc;
    logic                  id_mem_read;
    logic                  id_reg_write;

    logic                  flush;
    logic                  mem_stall;

    logic [REG_ADDR_W-1:0] exm_rd;
    logic                  exm_reg_write;
    logic [XLEN-1:0]       exm_result;
    logic [REG_ADDR_W-1:0] mwb_rd;
    logic                  mwb_reg_write;
    logic [XLEN-1:0]       mwb_data;

    logic                  id_stall;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_data1;
    logic [XLEN-1:0]       ex_data2;
    logic [ALU_SEL_W-1:0]  ex_select;
    logic [XLEN-1:0]       ex_store_data;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_reg_write;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_alu_select, id_alusrc,
               id_mem_read, id_reg_write, flush, mem_stall,
               exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_data,
        input  id_stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_select,
               ex_store_data, ex_rd_addr, ex_mem_read, ex_reg_write
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_alu_select, id_alusrc,
               id_mem_read, id_reg_write, flush, mem_stall,
               exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_data,
        output id_stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_select,
               ex_store_data, ex_rd_addr, ex_mem_read, ex_reg_write
    );

endinterface

// File: rtl/id_ex_pipeline_reg_forward_unit.sv
// Picks the freshest value of one source register: EX/MEM result, then
// MEM/WB data, then the value read from the register file in decode.
module forward_unit
    import id_ex_pipeline_reg_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic                  exm_reg_write,
    input  logic [XLEN-1:0]       exm_result,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic                  mwb_reg_write,
    input  logic [XLEN-1:0]       mwb_data,
    output logic [XLEN-1:0]       data
);

    fwd_src_e src;

    // x0 is hardwired to zero, so a pending write to it must never be forwarded.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
        src = FWD_REGFILE;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_addr)) begin
            src = FWD_EXM;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs_addr)) begin
            src = FWD_MWB;
        end
    end

    always_comb begin
        data = rs_data;
        unique case (src)
            FWD_EXM: data = exm_result;
            FWD_MWB: data = mwb_data;
            default: data = rs_data;
        endcase
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with flush, downstream stall, load-use bubble
// insertion and post-register operand forwarding.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    id_ex_pipeline_reg_if.slave bus
);

    ex_slot_t        slot;
    logic            load_use;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // A load in EX cannot feed its result to the instruction in decode in time.
    assign load_use = slot.valid && slot.mem_read && (slot.rd_addr != '0) &&
                      bus.id_valid &&
                      ((bus.id_rs1_addr == slot.rd_addr) ||
                       (bus.id_rs2_addr == slot.rd_addr));

    assign bus.id_stall = load_use | bus.mem_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the slot is a handful of flops, not a memory, so clearing all of it on reset is cheap and wanted.
            slot <= bubble();
        end else if (bus.flush) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            slot <= bubble();
        end else if (bus.mem_stall) begin
            slot <= slot;
        end else if (load_use || !bus.id_valid) begin
            slot <= bubble();
        end else begin
            slot <= '{
                valid:      1'b1,
                pc:         bus.id_pc,
                rs1_addr:   bus.id_rs1_addr,
                rs2_addr:   bus.id_rs2_addr,
                rd_addr:    bus.id_rd_addr,
                rs1_data:   bus.id_rs1_data,
                rs2_data:   bus.id_rs2_data,
                imm:        bus.id_imm,
                alu_select: bus.id_alu_select,
                alusrc:     bus.id_alusrc,
                mem_read:   bus.id_mem_read,
                reg_write:  bus.id_reg_write
            };
        end
    end

    forward_unit u_fwd_rs1 (
        .rs_addr       (slot.rs1_addr),
        .rs_data       (slot.rs1_data),
        .exm_rd        (bus.exm_rd),
        .exm_reg_write (bus.exm_reg_write),
        .exm_result    (bus.exm_result),
        .mwb_rd        (bus.mwb_rd),
        .mwb_reg_write (bus.mwb_reg_write),
        .mwb_data      (bus.mwb_data),
        .data          (rs1_fwd)
    );

    forward_unit u_fwd_rs2 (
        .rs_addr       (slot.rs2_addr),
        .rs_data       (slot.rs2_data),
        .exm_rd        (bus.exm_rd),
        .exm_reg_write (bus.exm_reg_write),
        .exm_result    (bus.exm_result),
        .mwb_rd        (bus.mwb_rd),
        .mwb_reg_write (bus.mwb_reg_write),
        .mwb_data      (bus.mwb_data),
        .data          (rs2_fwd)
    );

    assign bus.ex_valid      = slot.valid;
    assign bus.ex_pc         = slot.pc;
    assign bus.ex_data1      = rs1_fwd;
    assign bus.ex_data2      = slot.alusrc ? slot.imm : rs2_fwd;
    assign bus.ex_select     = slot.alu_select;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_rd_addr    = slot.rd_addr;
    assign bus.ex_mem_read   = slot.mem_read;
    assign bus.ex_reg_write  = slot.reg_write;

endmodule

// File: doc/id_ex_pipeline_reg.md
ID_EX_PIPELINE_REG -- requirements
Module: id_ex_pipeline_reg

Interface
REQ-001 SHALL expose: CLK  in  1  single clock, all state on rising edge.
REQ-002 SHALL expose: RESET  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL expose: ID_VALID in 1 decode slot holds an instruction; ID_PC in 32; ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR in 5 each; ID_RS1_DATA, ID_RS2_DATA, ID_IMM in 32 each; ID_ALU_SELECT in 4; ID_ALUSRC in 1 (1 = immediate as operand 2); ID_MEM_READ in 1; ID_REG_WRITE in 1.
REQ-004 SHALL expose: FLUSH in 1 squash EX slot (branch redirect); MEM_STALL in 1 downstream cannot accept.
REQ-005 SHALL expose forwarding sources: EXM_RD in 5, EXM_REG_WRITE in 1, EXM_RESULT in 32; MWB_RD in 5, MWB_REG_WRITE in 1, MWB_DATA in 32.
REQ-006 SHALL expose: ID_STALL out 1 hold IF/ID; EX_VALID out 1; EX_PC out 32; EX_DATA1, EX_DATA2 out 32 (ALU operands); EX_SELECT out 4 (ALU select); EX_STORE_DATA out 32; EX_RD_ADDR out 5; EX_MEM_READ out 1; EX_REG_WRITE out 1.

Function
REQ-007 SHALL register ID fields into the EX slot on each rising edge in capture mode; latency exactly one cycle.
REQ-008 SHALL apply per-edge priority: RESET > FLUSH > MEM_STALL (hold) > load-use bubble > capture.
REQ-009 FLUSH=1 SHALL load a bubble: EX_VALID, EX_REG_WRITE, EX_MEM_READ = 0; EX_SELECT = 4'b0000; PC, addresses, data, immediate fields = 0.
REQ-010 MEM_STALL=1 (no FLUSH) SHALL hold every EX slot register unchanged.
REQ-011 load_use SHALL be 1 when EX_VALID & EX_MEM_READ & EX_RD_ADDR!=0 & ID_VALID & (ID_RS1_ADDR==EX_RD_ADDR | ID_RS2_ADDR==EX_RD_ADDR).
REQ-012 load_use=1 (no FLUSH, no MEM_STALL) SHALL load a bubble per REQ-009 while ID holds.
REQ-013 ID_STALL SHALL equal load_use | MEM_STALL, combinational; FLUSH does not assert it.
REQ-014 ID_VALID=0 in capture mode SHALL load a bubble.
REQ-015 Forwarded rs1: EXM_RESULT if EXM_REG_WRITE & EXM_RD!=0 & EXM_RD==rs1; else MWB_DATA if MWB_REG_WRITE & MWB_RD!=0 & MWB_RD==rs1; else registered RS1_DATA; same rule for rs2.
REQ-016 EX/MEM source SHALL win when both match; register x0 SHALL never be forwarded.
REQ-017 EX_DATA1 SHALL be forwarded rs1; EX_DATA2 SHALL be registered IMM when ALUSRC=1, else forwarded rs2; EX_STORE_DATA SHALL always be forwarded rs2.
REQ-018 Forwarding muxes SHALL sit after the EX slot registers (combinational on registered addresses and live EXM/MWB inputs), no added latency.
REQ-019 EX_SELECT SHALL carry the 4-bit code unchanged; codes 0000 FWD, 0001 ADD, 0010 AND, 0011 OR; other codes pass through untouched.
REQ-020 All 32-bit values SHALL pass without extension or truncation.

Reset
REQ-021 RESET=0 SHALL immediately, without CLK, clear every EX slot register to a bubble (REQ-009 values).
REQ-022 During reset ID_STALL SHALL be driven by MEM_STALL only (load_use=0 because EX_VALID=0).
REQ-023 Reset release mid-stream SHALL resume capture on the first rising edge with RESET=1; no instruction held before reset reappears.

Structure
REQ-024 A shared package SHALL hold XLEN=32, REG_ADDR_W=5, ALU select constants (FWD, ADD, AND, OR) and the forward-source enum (REGFILE, EXM, MWB).
REQ-025 Forwarding selection SHALL be one sub-module, forward_unit, instantiated twice (rs1, rs2); hazard detection and slot registers stay in the top module.

Verification
REQ-026 Capture: ID rs1=x1 data 0x10, rs2=x2 data 0x20, ALUSRC=0, SELECT=0001 -> next cycle EX_VALID=1, EX_DATA1=0x10, EX_DATA2=0x20, EX_SELECT=0001.
REQ-027 Forward priority: EX slot rs1=x5, EXM_RD=5 result 0xAAAA, MWB_RD=5 data 0xBBBB, both writing -> EX_DATA1=0xAAAA; EXM_RD=0 -> 0xBBBB; both RD=0 -> regfile value.
REQ-028 Load-use: EX holds load to x3, ID uses rs2=x3 -> ID_STALL=1 one cycle, bubble (EX_VALID=0) enters EX, then instruction captured with ID_STALL=0.
REQ-029 FLUSH with MEM_STALL=1 same cycle -> EX_VALID=0, EX_REG_WRITE=0 next edge.
REQ-030 MEM_STALL=1 for 3 cycles -> EX outputs and EX_PC=0x0000_0040 constant, ID_STALL=1 throughout.
REQ-031 RESET=0 asserted between clock edges with valid slot -> EX_VALID=0 immediately; first edge after release captures ID.
